// File: rtl/dvv_ap_fifo.sv
// rtl/dvv_ap_fifo.sv - broadcast FIFO: one producer fanned out to SUBS subscribers over shared storage
// Optional lossy mode: define DVV_AP_FIFO_DROP_EN (adds drop_cnt port, drops oldest entry per full subscriber)
module dvv_ap_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int SUBS  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DW-1:0]                       wr_data,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [SUBS-1:0]                     sub_en,
    output logic [SUBS*DW-1:0]                  rd_data,
    output logic [SUBS-1:0]                     rd_valid,
    input  logic [SUBS-1:0]                     rd_ready,
    output logic [SUBS*($clog2(DEPTH)+1)-1:0]   rd_level
`ifdef DVV_AP_FIFO_DROP_EN
    ,
    output logic [SUBS*16-1:0]                  drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0]   mem_q    [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q [SUBS];
    logic [PW-1:0]   rd_ptr_d [SUBS];
    logic [CW-1:0]   cnt_q    [SUBS];
    logic [CW-1:0]   cnt_d    [SUBS];
    logic [SUBS-1:0] full;
    logic [SUBS-1:0] rd_fire;
    logic            wr_fire;
`ifdef DVV_AP_FIFO_DROP_EN
    logic [15:0]     drop_q   [SUBS];
    logic [15:0]     drop_d   [SUBS];
`endif

    // Per-subscriber status from registered counts only
    always_comb begin
        full     = '0;
        rd_valid = '0;
        rd_level = '0;
        for (int i = 0; i < SUBS; i++) begin
            full[i]                = sub_en[i] && (cnt_q[i] == CW'(DEPTH));
            rd_valid[i]            = sub_en[i] && (cnt_q[i] != '0);
            rd_level[i*CW +: CW]   = cnt_q[i];
        end
    end

    // Fall-through read data, forced to zero while the subscriber has nothing valid
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < SUBS; i++) begin
            if (rd_valid[i]) begin
                rd_data[i*DW +: DW] = mem_q[rd_ptr_q[i]];
            end
        end
    end

`ifdef DVV_AP_FIFO_DROP_EN
    assign wr_ready = 1'b1;
`else
    assign wr_ready = ~|full;
`endif
    assign wr_fire = wr_valid & wr_ready;
    assign rd_fire = rd_valid & rd_ready;

    // Pointer/count next state; disabled subscribers shadow the write pointer so they start empty
    always_comb begin
        wr_ptr_d = wr_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
        for (int i = 0; i < SUBS; i++) begin
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
`ifdef DVV_AP_FIFO_DROP_EN
            drop_d[i]   = drop_q[i];
`endif
            if (!sub_en[i]) begin
                cnt_d[i]    = '0;
                rd_ptr_d[i] = wr_ptr_d;
            end else begin
                if (rd_fire[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
                end
                if (wr_fire && !rd_fire[i]) begin
`ifdef DVV_AP_FIFO_DROP_EN
                    if (full[i]) begin
                        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
                        if (drop_q[i] != 16'hFFFF) begin
                            drop_d[i] = drop_q[i] + 16'd1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
`else
                    cnt_d[i] = cnt_q[i] + CW'(1);
`endif
                end else if (!wr_fire && rd_fire[i]) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

`ifdef DVV_AP_FIFO_DROP_EN
    // Expose the per-subscriber drop counters
    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < SUBS; i++) begin
            drop_cnt[i*16 +: 16] = drop_q[i];
        end
    end
`endif

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < SUBS; i++) begin
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
`ifdef DVV_AP_FIFO_DROP_EN
                drop_q[i]   <= '0;
`endif
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            for (int i = 0; i < SUBS; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
`ifdef DVV_AP_FIFO_DROP_EN
                drop_q[i]   <= drop_d[i];
`endif
            end
        end
    end

    // Shared storage, not reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
